bitonic_loader: RTL and testbench
=================================

# bitonic_loader

Input stage of the bitonic sorting network. Accepts a serial stream of DATA_WIDTH-bit keys over a valid/ready handshake and assembles N keys into one parallel block. When the block is complete it presents the block to the first compare-and-exchange column with a single-cycle `x_valid` pulse. A short block (terminated early by `s_last`) is padded with a direction-dependent sentinel, so the network always sorts exactly N keys and the padding collects at the tail of the sorted output.

## Interface
Parameters:
- `DATA_WIDTH`, 4, key width in bits, unsigned.
- `N`, 8, keys per block; power of two, at least 2.
- `CW`, $clog2(N)+1, derived; width of the key count.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ASCENDING`  in  1  sort direction for the block; sampled with the block's first key.
- `s_valid`  in  1  input key valid.
- `s_data`  in  DATA_WIDTH  input key.
- `s_last`  in  1  marks the final key of a block; qualified by `s_valid`.
- `s_ready`  out  1  loader can accept a key; equals (state == FILL).
- `x_flat`  out  N*DATA_WIDTH  block to the network; slot i is `x_flat[i*DATA_WIDTH +: DATA_WIDTH]`.
- `x_valid`  out  1  one-cycle pulse; `x_flat` is valid in that cycle.
- `x_dir`  out  1  `ASCENDING` value latched for the presented block.
- `x_count`  out  CW  number of real (non-pad) keys in the presented block, from 1 to N.

## Operation
- Handshake: a key is accepted on a rising edge when `s_valid && s_ready`. `s_data` is written to `buf[idx]` and `idx` increments.
- The first key of a block is the one accepted with `idx == 0`. On that key, `ASCENDING` is latched into `dir_r`.
- Pad value: all ones when `dir_r == 1`, zero otherwise. Padding therefore sorts to the high slots in either direction.
- State FILL:
  - The accepted key at `idx == N-1` completes the block, whether or not `s_last` is set.
  - An accepted key with `s_last` at `idx < N-1` records `cnt = idx+1` and moves to PAD.
- State PAD:
  - `s_ready` is 0 and one pad slot is written per cycle, at `idx+1` through `N-1`.
  - The write to slot N-1 completes the block and returns the state to FILL.
- Completion cycle: on the same edge as the final slot write, all of the following happen.
  - The buffer, including the final slot, is copied into `x_flat`.
  - `x_dir <= dir_r`.
  - `x_count <= cnt`, or N for a full block.
  - `x_valid <= 1` and `idx <= 0`.
- `x_flat`, `x_dir` and `x_count` hold their values until the next completion. `x_valid` returns to 0 on the following cycle.
- No backpressure from the network: the network never stalls, so `x_valid` is never held.
- Arithmetic: `idx` is $clog2(N) bits and never wraps past N-1. Comparisons are unsigned.

## Timing
- Reset values (asynchronous, while `rst_n` is 0):
  - state = FILL, `idx` = 0, `cnt` = 0, `buf` = 0, `dir_r` = 0.
  - `x_flat` = 0, `x_valid` = 0, `x_dir` = 0, `x_count` = 0.
  - `s_ready` = 1.
- Latency: `x_valid` is high in the cycle after the final slot write.
  - Full block: 1 cycle after the N-th key is accepted.
  - Short block of k keys: N-k cycles in PAD plus 1.
- Throughput: `s_ready` stays 1 during the completion cycle, so the first key of the next block can be accepted in the same cycle `x_valid` is high. Back-to-back full blocks produce one `x_valid` every N cycles.
- `s_last` on a key accepted at `idx == N-1` is a normal full block: no PAD cycles, `x_count` = N.
- `s_valid` low in FILL leaves all state unchanged. `s_data` and `s_last` are ignored while `s_ready` is 0.
- Reset mid-block discards the partial block; no `x_valid` is generated for it.
- `ASCENDING` changing mid-block has no effect on the block in progress.

## Structure
- Shared package `bitonic_pkg`:
  - State enum with values FILL and PAD.
  - Function `pad_value(dir)` returning the DATA_WIDTH-bit sentinel.
  - Localparams `IDX_W` and `CW`.
- The cae stage and the future unloader import the same package.
- No sub-module: the buffer, counter and FSM are inline. A single write port is muxed between `s_data` and `pad_value`.

## Test plan
- Full ascending block: N=8, keys 7,3,5,1,0,6,2,4, `s_valid` held high → `x_valid` pulses exactly 1 cycle after the 8th key; slots 0..7 hold 7,3,5,1,0,6,2,4; `x_count` = 8; `x_dir` = 1.
- Short block, ascending: 3 keys 2,9,4 with `s_last` on the third, `DATA_WIDTH` = 4 → `s_ready` low for 5 cycles; slots 3..7 = 0xF; `x_valid` 6 cycles after the third key; `x_count` = 3.
- Short block, descending: `ASCENDING` = 0 on the first key, single key 5 with `s_last` → slots 1..7 = 0; `x_dir` = 0; `x_count` = 1.
- Back-to-back blocks: 16 consecutive keys with no gaps → two `x_valid` pulses 8 cycles apart; `s_ready` never drops; the second block's first key is accepted in the first pulse's cycle.
- Gaps plus direction change: `s_valid` toggled randomly and `ASCENDING` flipped after the first key → block contents unchanged; `x_dir` equals the value sampled on the first key.
- Reset mid-block: `rst_n` pulsed low after 4 keys → all outputs 0 immediately; no `x_valid`; the next 8 keys form a clean block starting at slot 0.

Source files
------------

// File: rtl/bitonic_pkg.sv
// Shared definitions for the bitonic sorter: loader FSM states, default
// geometry and the padding sentinel used for short blocks.
package bitonic_pkg;

    localparam int KEY_W   = 4;
    localparam int BLOCK_N = 8;
    localparam int IDX_W   = $clog2(BLOCK_N);
    localparam int CW      = $clog2(BLOCK_N) + 1;

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } state_t;

    // All ones for ascending, zero for descending: the pad always sorts last.
    function automatic logic [KEY_W-1:0] pad_value(input logic dir);
        return {KEY_W{dir}};
    endfunction

endpackage

// File: rtl/bitonic_loader.sv
// Input stage of the bitonic network: collects N serial keys into one block,
// padding short blocks with a direction-dependent sentinel.
module bitonic_loader #(
    parameter int DATA_WIDTH = 4,
    parameter int N          = 8,
    parameter int CW         = $clog2(N) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ASCENDING,
    input  logic                    s_valid,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic [N*DATA_WIDTH-1:0] x_flat,
    output logic                    x_valid,
    output logic                    x_dir,
    output logic [CW-1:0]           x_count
);
    import bitonic_pkg::*;

    localparam int             IW       = $clog2(N);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    state_t                  state;
    state_t                  state_nx;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;
    logic                    dir_r;
    logic [DATA_WIDTH-1:0]   key_buf [N];

    logic                    accept;
    logic                    wr_en;
    logic                    last_slot;
    logic                    complete;
    logic [KEY_W-1:0]        pad_pkg;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [N*DATA_WIDTH-1:0] flat_nx;

    // Single write port: real keys in FILL, sentinel in PAD.
    always_comb begin
        s_ready   = (state == FILL);
        accept    = s_valid && s_ready;
        wr_en     = accept || (state == PAD);
        last_slot = (idx == LAST_IDX);
        complete  = wr_en && last_slot;
        pad_pkg   = pad_value(dir_r);
        wr_data   = (state == PAD) ? {DATA_WIDTH{|pad_pkg}} : s_data;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (accept && s_last && !last_slot) state_nx = PAD;
            PAD:     if (last_slot) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    // The presented block includes the slot being written on the completion edge.
    always_comb begin
        flat_nx = '0;
        for (int i = 0; i < N; i++) begin
            flat_nx[i*DATA_WIDTH +: DATA_WIDTH] = (IW'(i) == idx) ? wr_data : key_buf[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            cnt     <= '0;
            dir_r   <= 1'b0;
            x_flat  <= '0;
            x_valid <= 1'b0;
            x_dir   <= 1'b0;
            x_count <= '0;
            for (int i = 0; i < N; i++) key_buf[i] <= '0;
        end else begin
            x_valid <= complete;
            if (wr_en) begin
                key_buf[idx] <= wr_data;
                idx          <= last_slot ? '0 : idx + 1'b1;
            end
            if (accept && (idx == '0)) dir_r <= ASCENDING;
            if (accept && s_last && !last_slot) cnt <= CW'(idx) + CW'(1);
            if (complete) begin
                x_flat  <= flat_nx;
                x_dir   <= dir_r;
                x_count <= (state == PAD) ? cnt : CW'(N);
            end
        end
    end

endmodule

// File: tb/tb_bitonic_loader.sv
// Self-checking bench for bitonic_loader: random key streams compared against
// a block-level model (keys in order, sentinel-filled tail).
module tb_bitonic_loader;

    localparam int W  = 4;
    localparam int N  = 8;
    localparam int CW = $clog2(N) + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         asc = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic [W-1:0] s_data = '0;
    logic         s_ready;
    logic [N*W-1:0] x_flat;
    logic         x_valid;
    logic         x_dir;
    logic [CW-1:0] x_count;

    bitonic_loader #(.DATA_WIDTH(W), .N(N), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ASCENDING(asc),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .x_flat(x_flat), .x_valid(x_valid), .x_dir(x_dir), .x_count(x_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nr_cnt = 0;

    logic [N*W-1:0] exp_q[$];
    logic [N*W-1:0] got_flat_q[$];
    logic           got_dir_q[$];
    logic [CW-1:0]  got_cnt_q[$];
    int             got_cyc_q[$];

    // Observation only: records every presented block and counts not-ready cycles.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (x_valid) begin
            got_flat_q.push_back(x_flat);
            got_dir_q.push_back(x_dir);
            got_cnt_q.push_back(x_count);
            got_cyc_q.push_back(cyc);
        end
        if (!s_ready) nr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [N*W-1:0] model_block(input logic [W-1:0] keys[$], input logic dir);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (i < keys.size()) r[i*W +: W] = keys[i];
            else                 r[i*W +: W] = dir ? {W{1'b1}} : {W{1'b0}};
        end
        return r;
    endfunction

    task automatic clear_obs();
        exp_q.delete();
        got_flat_q.delete();
        got_dir_q.delete();
        got_cnt_q.delete();
        got_cyc_q.delete();
        nr_cnt = 0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds one key until accepted; key_cycle is the cycle in which the handshake happened.
    task automatic drive_key(input logic [W-1:0] d, input logic last, input logic a, output int key_cycle);
        bit done;
        int n;
        done = 0;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        asc     = a;
        while (!done) begin
            @(negedge clk);
            done = s_ready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 50) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout s_ready stayed 0 for %0d cycles, required 1", n);
                done = 1;
            end
        end
        key_cycle = cyc - 1;
    endtask

    task automatic run_block(input logic [W-1:0] keys[$], input logic a0, input logic flip,
                             input int max_gap, input logic use_last,
                             output int first_kc, output int last_kc);
        int kc;
        first_kc = 0;
        last_kc  = 0;
        for (int i = 0; i < keys.size(); i++) begin
            if (i > 0 && max_gap > 0) begin
                s_valid = 1'b0;
                s_data  = W'($urandom);
                s_last  = 1'($urandom);
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drive_key(keys[i], use_last && (i == keys.size() - 1), (flip && i > 0) ? ~a0 : a0, kc);
            if (i == 0) first_kc = kc;
            last_kc = kc;
        end
        // Offer junk while padding; it must be ignored.
        if (keys.size() < N) begin
            s_valid = 1'b1;
            s_data  = W'($urandom);
            s_last  = 1'b1;
            asc     = ~a0;
            repeat (N - keys.size()) @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int t;
        t = 0;
        while (got_flat_q.size() < n && t < budget) begin
            @(posedge clk);
            #2;
            t++;
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++; if (x_flat !== '0)  begin failures++; $display("FAIL reset_x_flat got=%h exp=0", x_flat); end
        checks++; if (x_valid !== 1'b0) begin failures++; $display("FAIL reset_x_valid got=%b exp=0", x_valid); end
        checks++; if (x_dir !== 1'b0) begin failures++; $display("FAIL reset_x_dir got=%b exp=0", x_dir); end
        checks++; if (x_count !== '0) begin failures++; $display("FAIL reset_x_count got=%0d exp=0", x_count); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_full_asc();
        logic [W-1:0] keys[$];
        int fk, lk;
        keys = '{4'd7, 4'd3, 4'd5, 4'd1, 4'd0, 4'd6, 4'd2, 4'd4};
        clear_obs();
        exp_q.push_back(model_block(keys, 1'b1));
        run_block(keys, 1'b1, 1'b0, 0, 1'b0, fk, lk);
        wait_pulses(1, 30);
        checks++; if (got_flat_q.size() !== 1) begin failures++; $display("FAIL full_pulses got=%0d exp=1", got_flat_q.size()); end
        if (got_flat_q.size() >= 1) begin
            checks++; if (got_flat_q[0] !== exp_q[0]) begin failures++; $display("FAIL full_flat got=%h exp=%h", got_flat_q[0], exp_q[0]); end
            checks++; if (got_cnt_q[0] !== CW'(8)) begin failures++; $display("FAIL full_count got=%0d exp=8", got_cnt_q[0]); end
            checks++; if (got_dir_q[0] !== 1'b1) begin failures++; $display("FAIL full_dir got=%b exp=1", got_dir_q[0]); end
            checks++; if (got_cyc_q[0] - lk !== 1) begin failures++; $display("FAIL full_latency got=%0d exp=1", got_cyc_q[0] - lk); end
        end
        checks++; if (nr_cnt !== 0) begin failures++; $display("FAIL full_not_ready got=%0d exp=0", nr_cnt); end
    endtask

    task automatic test_short(input string name, input logic [W-1:0] keys[$], input logic a0);
        int fk, lk, k;
        k = keys.size();
        clear_obs();
        exp_q.push_back(model_block(keys, a0));
        run_block(keys, a0, 1'b0, 0, 1'b1, fk, lk);
        wait_pulses(1, 30);
        checks++; if (got_flat_q.size() !== 1) begin failures++; $display("FAIL %s_pulses got=%0d exp=1", name, got_flat_q.size()); end
        if (got_flat_q.size() >= 1) begin
            checks++; if (got_flat_q[0] !== exp_q[0]) begin failures++; $display("FAIL %s_flat got=%h exp=%h", name, got_flat_q[0], exp_q[0]); end
            checks++; if (got_cnt_q[0] !== CW'(k)) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", name, got_cnt_q[0], k); end
            checks++; if (got_dir_q[0] !== a0) begin failures++; $display("FAIL %s_dir got=%b exp=%b", name, got_dir_q[0], a0); end
            checks++; if (got_cyc_q[0] - lk !== N - k + 1) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, got_cyc_q[0] - lk, N - k + 1); end
        end
        checks++; if (nr_cnt !== N - k) begin failures++; $display("FAIL %s_not_ready got=%0d exp=%0d", name, nr_cnt, N - k); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] k0[$];
        logic [W-1:0] k1[$];
        int fk0, lk0, fk1, lk1;
        clear_obs();
        for (int i = 0; i < N; i++) begin
            k0.push_back(W'($urandom));
            k1.push_back(W'($urandom));
        end
        exp_q.push_back(model_block(k0, 1'b1));
        exp_q.push_back(model_block(k1, 1'b0));
        run_block(k0, 1'b1, 1'b0, 0, 1'b0, fk0, lk0);
        run_block(k1, 1'b0, 1'b0, 0, 1'b1, fk1, lk1);
        wait_pulses(2, 40);
        checks++; if (got_flat_q.size() !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", got_flat_q.size()); end
        if (got_flat_q.size() >= 2) begin
            checks++; if (got_flat_q[0] !== exp_q[0]) begin failures++; $display("FAIL b2b_flat0 got=%h exp=%h", got_flat_q[0], exp_q[0]); end
            checks++; if (got_flat_q[1] !== exp_q[1]) begin failures++; $display("FAIL b2b_flat1 got=%h exp=%h", got_flat_q[1], exp_q[1]); end
            checks++; if (got_dir_q[1] !== 1'b0) begin failures++; $display("FAIL b2b_dir1 got=%b exp=0", got_dir_q[1]); end
            checks++; if (got_cyc_q[1] - got_cyc_q[0] !== N) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", got_cyc_q[1] - got_cyc_q[0], N); end
            checks++; if (fk1 !== got_cyc_q[0]) begin failures++; $display("FAIL b2b_overlap got=%0d exp=%0d", fk1, got_cyc_q[0]); end
        end
        checks++; if (nr_cnt !== 0) begin failures++; $display("FAIL b2b_not_ready got=%0d exp=0", nr_cnt); end
    endtask

    task automatic test_gaps_dir_flip();
        for (int it = 0; it < 4; it++) begin
            logic [W-1:0] keys[$];
            logic a0;
            int k, fk, lk, lat;
            k  = (it == 0) ? N : $urandom_range(1, N);
            a0 = 1'($urandom);
            for (int i = 0; i < k; i++) keys.push_back(W'($urandom));
            lat = (k == N) ? 1 : N - k + 1;
            clear_obs();
            exp_q.push_back(model_block(keys, a0));
            run_block(keys, a0, 1'b1, 3, 1'b1, fk, lk);
            wait_pulses(1, 40);
            checks++; if (got_flat_q.size() !== 1) begin failures++; $display("FAIL gap%0d_pulses got=%0d exp=1", it, got_flat_q.size()); end
            if (got_flat_q.size() >= 1) begin
                checks++; if (got_flat_q[0] !== exp_q[0]) begin failures++; $display("FAIL gap%0d_flat got=%h exp=%h", it, got_flat_q[0], exp_q[0]); end
                checks++; if (got_dir_q[0] !== a0) begin failures++; $display("FAIL gap%0d_dir got=%b exp=%b", it, got_dir_q[0], a0); end
                checks++; if (got_cnt_q[0] !== CW'(k)) begin failures++; $display("FAIL gap%0d_count got=%0d exp=%0d", it, got_cnt_q[0], k); end
                checks++; if (got_cyc_q[0] - lk !== lat) begin failures++; $display("FAIL gap%0d_latency got=%0d exp=%0d", it, got_cyc_q[0] - lk, lat); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] pre[$];
        logic [W-1:0] keys[$];
        int fk, lk, kc;
        pre = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        run_block(pre, 1'b1, 1'b0, 0, 1'b0, fk, lk);
        idle(2);
        for (int i = 0; i < 4; i++) drive_key(W'($urandom), 1'b0, 1'b1, kc);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (x_flat !== '0)  begin failures++; $display("FAIL rst_mid_x_flat got=%h exp=0", x_flat); end
        checks++; if (x_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_x_valid got=%b exp=0", x_valid); end
        checks++; if (x_dir !== 1'b0) begin failures++; $display("FAIL rst_mid_x_dir got=%b exp=0", x_dir); end
        checks++; if (x_count !== '0) begin failures++; $display("FAIL rst_mid_x_count got=%0d exp=0", x_count); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        idle(12);
        checks++; if (got_flat_q.size() !== 0) begin failures++; $display("FAIL rst_mid_stray_pulse got=%0d exp=0", got_flat_q.size()); end
        for (int i = 0; i < N; i++) keys.push_back(W'($urandom_range(1, 15)));
        exp_q.push_back(model_block(keys, 1'b0));
        run_block(keys, 1'b0, 1'b0, 0, 1'b0, fk, lk);
        wait_pulses(1, 30);
        checks++; if (got_flat_q.size() !== 1) begin failures++; $display("FAIL rst_clean_pulses got=%0d exp=1", got_flat_q.size()); end
        if (got_flat_q.size() >= 1) begin
            checks++; if (got_flat_q[0] !== exp_q[0]) begin failures++; $display("FAIL rst_clean_flat got=%h exp=%h", got_flat_q[0], exp_q[0]); end
            checks++; if (got_cnt_q[0] !== CW'(N)) begin failures++; $display("FAIL rst_clean_count got=%0d exp=%0d", got_cnt_q[0], N); end
            checks++; if (got_cyc_q[0] - lk !== 1) begin failures++; $display("FAIL rst_clean_latency got=%0d exp=1", got_cyc_q[0] - lk); end
        end
    endtask

    initial begin
        logic [W-1:0] sa[$];
        logic [W-1:0] sd[$];
        sa = '{4'd2, 4'd9, 4'd4};
        sd = '{4'd5};
        test_reset();
        test_full_asc();
        test_short("short_asc", sa, 1'b1);
        test_short("short_desc", sd, 1'b0);
        test_back_to_back();
        test_gaps_dir_flip();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
